// File: rtl/ps2_host_phy_pkg.sv
// Shared constants for the PS/2 host PHY: FSM encodings, error codes and
// the microsecond-to-cycle conversion used to size all timers.
package ps2_host_phy_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_RX           = 3'd1;
  localparam logic [2:0] ST_TX_INHIBIT   = 3'd2;
  localparam logic [2:0] ST_TX_RTS       = 3'd3;
  localparam logic [2:0] ST_TX_SHIFT     = 3'd4;
  localparam logic [2:0] ST_TX_ACK       = 3'd5;
  localparam logic [2:0] ST_TX_WAIT_IDLE = 3'd6;

  localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
  localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
  localparam logic [1:0] PS2_ERR_FRAME   = 2'b10;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

  function automatic int unsigned us_to_cyc(int unsigned freq_hz, int unsigned us);
    return (freq_hz / 32'd1000000) * us;
  endfunction

  // Parity bit that makes data+parity carry an odd number of ones
  function automatic logic odd_par(logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_host_phy_if.sv
// User-side bus of the PS/2 host PHY: TX request/status and RX FIFO read port.
interface ps2_host_phy_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       rx_overflow;
  logic       busy;

  modport master (
    output tx_data, tx_req, rx_rd,
    input  tx_ready, tx_done, tx_err, rx_data, rx_valid, rx_err,
           rx_err_code, rx_overflow, busy
  );

  modport slave (
    input  tx_data, tx_req, rx_rd,
    output tx_ready, tx_done, tx_err, rx_data, rx_valid, rx_err,
           rx_err_code, rx_overflow, busy
  );
endinterface

// File: rtl/ps2_host_phy_rx_fifo.sv
// First-word-fall-through synchronous FIFO for received bytes. A push while
// full is accepted only if a pop frees the head slot in the same cycle.
module ps2_host_phy_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic [AW:0]                 cnt;
  logic                        do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
endmodule

// File: rtl/ps2_host_phy.sv
// Host-side PS/2 PHY: conditions the open-drain pins, receives and checks
// device frames into a FIFO, and runs the host-to-device send sequence.
module ps2_host_phy
  import ps2_host_phy_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned INHIBIT_US     = 100,
  parameter int unsigned FIRST_CLK_US   = 15000,
  parameter int unsigned BIT_TIMEOUT_US = 2000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  ps2_host_phy_if.slave bus,
  inout  wire           ps2_clk,
  inout  wire           ps2_data
);
  localparam int unsigned INHIBIT_CYC = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned FIRST_CYC   = us_to_cyc(CLK_FREQ_HZ, FIRST_CLK_US);
  localparam int unsigned BIT_CYC     = us_to_cyc(CLK_FREQ_HZ, BIT_TIMEOUT_US);
  localparam int unsigned MAX_CYC =
    (INHIBIT_CYC > FIRST_CYC) ? ((INHIBIT_CYC > BIT_CYC) ? INHIBIT_CYC : BIT_CYC)
                              : ((FIRST_CYC > BIT_CYC) ? FIRST_CYC : BIT_CYC);
  localparam int TW  = $clog2(MAX_CYC + 1);
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [1:0]     clk_sync, data_sync;
  logic           data_s, filt, fall;
  logic [FCW-1:0] fcnt;
  logic [2:0]     state;
  logic [TW-1:0]  tmr;
  logic [3:0]     bcnt;
  logic [8:0]     rx_sr, tx_sr;
  logic           clk_oe, data_oe;
  logic           push;
  logic [7:0]     push_byte;
  logic           fifo_empty, fifo_full;

  // Registered open-drain drivers; reset clears them asynchronously
  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;

  assign data_s = data_sync[1];
  // Falling edge fires in the cycle the filter accepts the new low level
  assign fall   = filt && !clk_sync[1] && (fcnt == FCW'(FILTER_LEN - 1));

  assign bus.tx_ready = (state == ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.rx_valid = !fifo_empty;

  // Two-flop synchronisers for both pins (idle level is high)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end

  // Clock glitch filter: flip only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_sync[1] == filt) begin
      fcnt <= '0;
    end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
      filt <= clk_sync[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end

  // Main protocol FSM with shared watchdog timer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state           <= ST_IDLE;
      tmr             <= '0;
      bcnt            <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      clk_oe          <= 1'b0;
      data_oe         <= 1'b0;
      bus.tx_done     <= 1'b0;
      bus.tx_err      <= 1'b0;
      bus.rx_err      <= 1'b0;
      bus.rx_err_code <= PS2_ERR_NONE;
      push            <= 1'b0;
      push_byte       <= '0;
    end else begin
      bus.tx_done <= 1'b0;
      bus.tx_err  <= 1'b0;
      bus.rx_err  <= 1'b0;
      push        <= 1'b0;
      case (state)
        ST_IDLE:
          if (bus.tx_req) begin
            // Inhibit also aborts any frame the device may have started
            tx_sr  <= {odd_par(bus.tx_data), bus.tx_data};
            tmr    <= TW'(INHIBIT_CYC);
            clk_oe <= 1'b1;
            state  <= ST_TX_INHIBIT;
          end else if (fall && !data_s) begin
            bcnt  <= '0;
            tmr   <= TW'(BIT_CYC);
            state <= ST_RX;
          end
        ST_RX:
          if (fall) begin
            tmr <= TW'(BIT_CYC);
            if (bcnt == 4'd9) begin
              state <= ST_IDLE;
              if (!(^rx_sr)) begin
                bus.rx_err      <= 1'b1;
                bus.rx_err_code <= PS2_ERR_PARITY;
              end else if (!data_s) begin
                bus.rx_err      <= 1'b1;
                bus.rx_err_code <= PS2_ERR_FRAME;
              end else begin
                push      <= 1'b1;
                push_byte <= rx_sr[7:0];
              end
            end else begin
              rx_sr <= {data_s, rx_sr[8:1]};
              bcnt  <= bcnt + 1'b1;
            end
          end else if (tmr == '0) begin
            bus.rx_err      <= 1'b1;
            bus.rx_err_code <= PS2_ERR_TIMEOUT;
            state           <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        ST_TX_INHIBIT:
          if (tmr == '0) state <= ST_TX_RTS;
          else           tmr   <= tmr - 1'b1;
        ST_TX_RTS: begin
          data_oe <= 1'b1;
          clk_oe  <= 1'b0;
          tmr     <= TW'(FIRST_CYC);
          bcnt    <= '0;
          state   <= ST_TX_SHIFT;
        end
        ST_TX_SHIFT:
          if (fall) begin
            tmr <= TW'(BIT_CYC);
            if (bcnt == 4'd9) begin
              data_oe <= 1'b0;
              state   <= ST_TX_ACK;
            end else begin
              // Data bits LSB first, then the parity bit
              data_oe <= ~tx_sr[0];
              tx_sr   <= {1'b1, tx_sr[8:1]};
              bcnt    <= bcnt + 1'b1;
            end
          end else if (tmr == '0) begin
            clk_oe     <= 1'b0;
            data_oe    <= 1'b0;
            bus.tx_err <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        ST_TX_ACK:
          if (fall) begin
            if (!data_s) begin
              tmr   <= TW'(BIT_CYC);
              state <= ST_TX_WAIT_IDLE;
            end else begin
              bus.tx_err <= 1'b1;
              state      <= ST_IDLE;
            end
          end else if (tmr == '0) begin
            bus.tx_err <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        ST_TX_WAIT_IDLE:
          if (filt && data_s) begin
            bus.tx_done <= 1'b1;
            state       <= ST_IDLE;
          end else if (tmr == '0) begin
            bus.tx_err <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        default: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end

  // Sticky overflow: a good byte dropped because no slot was freed
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                            bus.rx_overflow <= 1'b0;
    else if (push && fifo_full && !bus.rx_rd) bus.rx_overflow <= 1'b1;

  ps2_host_phy_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .wdata (push_byte),
    .pop   (bus.rx_rd),
    .rdata (bus.rx_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: tb/tb_ps2_host_phy.sv
// Bench for ps2_host_phy: a PS/2 device model on pulled-up pins, a queue
// model of the RX FIFO and frame rules computed from bit counts.
`timescale 1ns/1ps
module tb_ps2_host_phy;
  localparam int CLK_HZ    = 1000000;  // one cycle per microsecond
  localparam int INH_CYC   = 10;
  localparam int FIRST_CYC = 300;
  localparam int BIT_CYC   = 100;
  localparam int FLT       = 4;
  localparam int DEPTH     = 4;
  localparam int HALF      = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wire ps2_clk, ps2_data;
  pullup (ps2_clk);
  pullup (ps2_data);
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_phy_if bus();

  ps2_host_phy #(
    .CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_CYC), .FIRST_CLK_US(FIRST_CYC),
    .BIT_TIMEOUT_US(BIT_CYC), .FILTER_LEN(FLT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  int cyc_n = 0, rx_err_n = 0, rx_err_at = 0, tx_done_n = 0, tx_err_n = 0, tx_err_at = 0;
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (bus.rx_err)  begin rx_err_n++; rx_err_at = cyc_n; end
    if (bus.tx_done) tx_done_n++;
    if (bus.tx_err)  begin tx_err_n++; tx_err_at = cyc_n; end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO as a queue, frame rules from ones-counts
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic [1:0] exp_code = 2'b00;
  int         last_fall = 0;

  function automatic logic par_of(logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic dev_bit(logic b);
    dev_data_low = !b;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    last_fall = cyc_n;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
  endtask

  task automatic dev_frame(logic [7:0] b, logic par, logic stop);
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(b[i]);
    dev_bit(par);
    dev_bit(stop);
    dev_data_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic rx_frame_chk(string tag, logic [7:0] b, logic par, logic stop);
    int e0;
    logic exp_err;
    e0 = rx_err_n;
    exp_err = 1'b1;
    if ((($countones(b) + int'(par)) % 2) == 0) exp_code = 2'b01;
    else if (!stop)                             exp_code = 2'b10;
    else begin
      exp_err = 1'b0;
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else                       exp_q.push_back(b);
    end
    dev_frame(b, par, stop);
    chk({tag, " rx_err"}, rx_err_n - e0, {31'd0, exp_err});
    chk({tag, " code"}, {30'd0, bus.rx_err_code}, {30'd0, exp_code});
    chk({tag, " ovf"}, {31'd0, bus.rx_overflow}, {31'd0, exp_ovf});
  endtask

  task automatic rx_pop_chk(string tag);
    logic [7:0] e;
    @(negedge clk);
    chk({tag, " valid"}, {31'd0, bus.rx_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, " data"}, {24'd0, bus.rx_data}, {24'd0, e});
      bus.rx_rd = 1'b1;
      @(negedge clk);
      bus.rx_rd = 1'b0;
    end
  endtask

  task automatic tx_run(string tag, logic [7:0] b, logic ack);
    int d0, e0, lowc, t;
    logic [9:0] got;
    d0 = tx_done_n; e0 = tx_err_n; lowc = 0; t = 0;
    @(negedge clk);
    chk({tag, " ready"}, {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_data = b; bus.tx_req = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    while (ps2_clk !== 1'b0 && t < 10) begin @(negedge clk); t++; end
    while (ps2_clk === 1'b0 && lowc < 1000) begin @(negedge clk); lowc++; end
    chk({tag, " inhibit"}, {31'd0, lowc >= INH_CYC && lowc < 1000}, 32'd1);
    chk({tag, " rts"}, {31'd0, ps2_data}, 32'd0);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      got[i] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    chk({tag, " byte"}, {24'd0, got[7:0]}, {24'd0, b});
    chk({tag, " parity"}, {31'd0, got[8]}, {31'd0, par_of(b)});
    chk({tag, " stop"}, {31'd0, got[9]}, 32'd1);
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
    t = 0;
    while (tx_done_n == d0 && tx_err_n == e0 && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk({tag, " done"}, tx_done_n - d0, {31'd0, ack});
    chk({tag, " err"}, tx_err_n - e0, {31'd0, !ack});
    chk({tag, " idle"}, {30'd0, bus.tx_ready, bus.busy}, 32'd2);
    chk({tag, " pins"}, {30'd0, ps2_clk, ps2_data}, 32'd3);
  endtask

  initial begin
    int t, t0, e0;
    logic [7:0] b;
    bus.tx_data = '0; bus.tx_req = 1'b0; bus.rx_rd = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst pins", {30'd0, ps2_clk, ps2_data}, 32'd3);
    chk("rst ready/busy", {30'd0, bus.tx_ready, bus.busy}, 32'd2);
    chk("rst rx", {20'd0, bus.rx_valid, bus.rx_data, bus.rx_err_code, bus.rx_overflow},
        32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed RX frames
    rx_frame_chk("rx fa", 8'hFA, 1'b1, 1'b1);
    rx_pop_chk("pop fa");
    rx_pop_chk("pop empty");
    rx_frame_chk("rx aa par", 8'hAA, 1'b0, 1'b1);
    rx_pop_chk("after par");
    rx_frame_chk("rx aa stop", 8'hAA, 1'b1, 1'b0);
    rx_pop_chk("after stop");

    // Randomised RX frames with error injection
    for (int i = 0; i < 8; i++) begin
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 3);
      rx_frame_chk("rx rand", b, (kind == 0) ? !par_of(b) : par_of(b), kind != 1);
      rx_pop_chk("pop rand");
    end

    // TX with ACK, directed then random
    tx_run("tx f4", 8'hF4, 1'b1);
    for (int i = 0; i < 3; i++) tx_run("tx rand", 8'($urandom), 1'b1);
    tx_run("tx noack", 8'($urandom), 1'b0);

    // TX with a device that never clocks
    e0 = tx_err_n;
    @(negedge clk);
    bus.tx_data = 8'h55; bus.tx_req = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    t = 0;
    while (ps2_data !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    t0 = cyc_n;
    t = 0;
    while (tx_err_n == e0 && t < 1000) begin @(negedge clk); t++; end
    chk("first clk timeout", {31'd0, tx_err_n != e0 && (tx_err_at - t0) >= FIRST_CYC &&
        (tx_err_at - t0) <= FIRST_CYC + 5}, 32'd1);
    @(negedge clk);
    chk("first clk pins", {30'd0, ps2_clk, ps2_data}, 32'd3);
    chk("first clk idle", {31'd0, bus.tx_ready}, 32'd1);

    // RX stalls after four bits
    e0 = rx_err_n;
    dev_bit(1'b0); dev_bit(1'b1); dev_bit(1'b0); dev_bit(1'b1);
    dev_data_low = 1'b0;
    t = 0;
    while (rx_err_n == e0 && t < 400) begin @(negedge clk); t++; end
    chk("rx timeout time", {31'd0, rx_err_n == e0 + 1 && (rx_err_at - last_fall) >= BIT_CYC &&
        (rx_err_at - last_fall) <= BIT_CYC + 15}, 32'd1);
    chk("rx timeout code", {30'd0, bus.rx_err_code}, 32'd3);
    exp_code = 2'b11;
    rx_frame_chk("rx 00", 8'h00, 1'b1, 1'b1);
    rx_pop_chk("pop 00");

    // Overflow: five good bytes, no reads
    for (int i = 1; i <= 5; i++) rx_frame_chk("rx ovf", 8'(i), par_of(8'(i)), 1'b1);
    for (int i = 0; i < 5; i++) rx_pop_chk("pop ovf");

    // Reset in the middle of TX_SHIFT with a byte waiting in the FIFO
    rx_frame_chk("rx pre", 8'h5A, par_of(8'h5A), 1'b1);
    @(negedge clk);
    bus.tx_data = 8'h00; bus.tx_req = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    t = 0;
    while (ps2_data !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      dev_clk_low = 1'b1; repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0; repeat (HALF) @(negedge clk);
    end
    chk("shift data low", {30'd0, bus.busy, ps2_data}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst pins", {30'd0, ps2_clk, ps2_data}, 32'd3);
    chk("mid rst ready/busy", {30'd0, bus.tx_ready, bus.busy}, 32'd2);
    chk("mid rst rx", {20'd0, bus.rx_valid, bus.rx_data, bus.rx_err_code, bus.rx_overflow},
        32'd0);
    exp_q.delete(); exp_ovf = 1'b0; exp_code = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    b = 8'($urandom);
    rx_frame_chk("rx post", b, par_of(b), 1'b1);
    rx_pop_chk("pop post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_phy.md
Name: ps2_host_phy

Overview:
- Parametrised host-side PS/2 physical-layer controller. Successor to the current single-byte RX/TX driver.
- Adds:
  - clock-frequency-derived timing
  - full RX frame checking (start, odd parity, stop)
  - TX acknowledge checking
  - bit-to-bit watchdog timeouts
  - an RX FIFO with a valid/ready read interface.
- Sits between the open-drain ps2_clk/ps2_data pins and the mouse/keyboard protocol FSMs of the Paint project.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency; all timing is derived from it.
- INHIBIT_US, 100, time the host holds ps2_clk low before request-to-send.
- FIRST_CLK_US, 15000, maximum wait for the device's first clock after request-to-send.
- BIT_TIMEOUT_US, 2000, maximum gap between filtered falling edges inside a frame.
- FILTER_LEN, 8, glitch-filter length in cycles for ps2_clk.
- FIFO_DEPTH, 4, RX FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send to the device.
- tx_req  in  1  send request; accepted only when tx_ready=1.
- tx_ready  out  1  high in IDLE only.
- tx_done  out  1  one-cycle pulse: byte sent and ACK seen.
- tx_err  out  1  one-cycle pulse: missing ACK or timeout during TX.
- rx_data  out  8  FIFO head (first-word fall-through).
- rx_valid  out  1  FIFO not empty.
- rx_rd  in  1  pop the FIFO head.
- rx_err  out  1  one-cycle pulse: bad frame or RX timeout.
- rx_err_code  out  2  01 parity, 10 start/stop, 11 timeout; held until the next rx_err.
- rx_overflow  out  1  sticky; set when a good byte arrives with the FIFO full; cleared only by reset.
- busy  out  1  high in any state other than IDLE.
- ps2_clk  inout  1  open-drain; drive 0 or Z.
- ps2_data  inout  1  open-drain; drive 0 or Z.

Behaviour:
- Reset values:
  - all pulses 0; rx_err_code=00; rx_overflow=0; FIFO empty; rx_valid=0; rx_data=0.
  - both pins released (Z) immediately and asynchronously; state IDLE; tx_ready=1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - Clock filter: the filtered ps2_clk changes only after FILTER_LEN identical consecutive samples.
  - fall = one-cycle pulse on the filtered 1→0 transition.
  - ps2_data is sampled from its synchronised value in the cycle of fall.
- Derived constants (cycles): INHIBIT_CYC, FIRST_CYC and BIT_CYC = CLK_FREQ_HZ/1e6 × the matching _US parameter. The timer width is $clog2 of the largest.
- States: IDLE, RX, TX_INHIBIT, TX_RTS, TX_SHIFT, TX_ACK, TX_WAIT_IDLE.
- IDLE:
  - tx_req → latch {odd parity, tx_data}; load INHIBIT_CYC; go to TX_INHIBIT.
  - Otherwise fall with data=0 → go to RX; bit count=0.
  - tx_req and fall in the same cycle: TX wins; the partial device frame is aborted by the inhibit.
  - fall with data=1 in IDLE → ignored (bad start, no error).
- RX:
  - Receives 8 data bits LSB-first, then parity, then stop, one per fall.
  - After the stop bit, return to IDLE and run the checks in priority order:
    - parity (odd over data+parity) fails → rx_err, code 01;
    - else stop=0 → rx_err, code 10;
    - else push to the FIFO.
  - Errored bytes are never pushed.
  - No fall within BIT_CYC → rx_err, code 11; go to IDLE.
- TX_INHIBIT: drive clk low for INHIBIT_CYC cycles, then go to TX_RTS.
- TX_RTS:
  - Drive data low, release clk; load FIRST_CYC; go to TX_SHIFT.
  - Data stays low (start bit) until the first fall.
- TX_SHIFT:
  - On fall k=1..8, drive data bit k−1 (0 → drive low, 1 → Z). On fall 9, drive parity. On fall 10, release data (stop bit).
  - Timer reloads to BIT_CYC on each fall.
  - Timeout → release both lines; tx_err; go to IDLE.
- TX_ACK:
  - On the next fall, sample data. 0 → go to TX_WAIT_IDLE; 1 → tx_err, go to IDLE.
  - Timeout → tx_err.
- TX_WAIT_IDLE:
  - Wait until filtered clk=1 and synchronised data=1, then pulse tx_done and go to IDLE.
  - Timeout → tx_err.
- tx_req outside IDLE is ignored; there is no queueing.
- FIFO:
  - Push and pop in the same cycle when full → both happen; count unchanged; no overflow.
  - Pop when empty → ignored.
  - Push when full → byte dropped; rx_overflow set.
  - Latency from the stop-bit fall to rx_valid: 2 cycles.
- Pin drivers are registered, so the pins are glitch-free.

Decomposition:
- Shared header ps2_defs.vh holds:
  - state encodings;
  - rx_err_code values PS2_ERR_PARITY, PS2_ERR_FRAME and PS2_ERR_TIMEOUT;
  - the microseconds-to-cycles conversion macro.
- Sub-module ps2_rx_fifo (parametrised synchronous FIFO: DEPTH, WIDTH=8, FWFT, full/empty).
- The glitch filter stays inline.

Test Plan:
- Device sends 0xFA (parity 1, stop 1) → after 2 cycles, rx_valid=1 and rx_data=0xFA; rx_rd empties the FIFO; no rx_err.
- Device sends 0xAA with parity 0 → rx_err pulse, rx_err_code=01, rx_valid stays 0. The same frame with stop=0 and correct parity → code 10.
- tx_req with tx_data=0xF4:
  - clk held low ≥ INHIBIT_CYC; then data low;
  - device-model sampling on rising edges reads 0xF4, parity 0, stop 1;
  - model ACKs → one tx_done pulse, tx_ready=1.
- TX with the model never ACKing (data high at fall 11) → tx_err, no tx_done. Model never clocking after RTS → tx_err after FIRST_CYC, both pins Z.
- Device stops clocking after 4 RX bits → rx_err code 11 exactly BIT_CYC after the last fall; the next full frame 0x00 (parity 1) is received correctly.
- FIFO_DEPTH=4, 5 good bytes 0x01..0x05 with no reads → rx_overflow=1; reads return 0x01..0x04. Separately, asserting reset_n=0 mid-TX_SHIFT → pins Z in the same cycle, state IDLE, FIFO empty.
